// File: rtl/riscv_pkg.sv
// riscv_pkg: shared branch funct3 codes, resolve FSM states and PC width
package riscv_pkg;
  localparam int PC_W = 32;
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;
  typedef enum logic {IDLE = 1'b0, SHADOW = 1'b1} brn_state_e;
endpackage

// File: rtl/brn_cmp.sv
// brn_cmp: combinational branch condition evaluator; reserved funct3 010/011 is illegal and not taken
module brn_cmp
  import riscv_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [PC_W-1:0] a,
  input  logic [PC_W-1:0] b,
  output logic            taken,
  output logic            illegal
);
  logic eq, lt, ltu;
  always_comb begin
    eq = a == b;
    lt = $signed(a) < $signed(b);
    ltu = a < b;
    illegal = funct3[2:1] == 2'b01;
    taken = funct3 == F3_BEQ  ? eq  :
            funct3 == F3_BNE  ? !eq :
            funct3 == F3_BLT  ? lt  :
            funct3 == F3_BGE  ? !lt :
            funct3 == F3_BLTU ? ltu :
            funct3 == F3_BGEU ? !ltu : 1'b0;
  end
endmodule

// File: rtl/ex_brn_resolve.sv
// ex_brn_resolve: execute-stage branch/jump resolution with registered redirect and predictor update.
// Optional BRN_PERF_CNT_EN enables the resolved-branch and misprediction counters.
module ex_brn_resolve
  import riscv_pkg::*;
#(
  parameter int SHADOW_CYCLES = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            valid_ex_i,
  input  logic            is_b_type_ex_i,
  input  logic            jump_ex_i,
  input  logic            brn_pred_ex_i,
  input  logic [2:0]      funct3_ex_i,
  input  logic [PC_W-1:0] r_data_p1_ex_i,
  input  logic [PC_W-1:0] r_data_p2_ex_i,
  input  logic [PC_W-1:0] curr_pc_ex_i,
  input  logic [PC_W-1:0] next_seq_pc_ex_i,
  input  logic [PC_W-1:0] next_brn_pc_ex_i,
  input  logic [PC_W-1:0] next_pred_pc_ex_i,
  input  logic [PC_W-1:0] jump_tgt_ex_i,
  output logic            redirect_o,
  output logic [PC_W-1:0] redirect_pc_o,
  output logic            flush_ex_o,
  output logic            bp_upd_valid_o,
  output logic [PC_W-1:0] bp_upd_pc_o,
  output logic            bp_upd_taken_o,
  output logic [PC_W-1:0] bp_upd_tgt_o,
  output logic            illegal_brn_o,
  output logic [31:0]     perf_brn_cnt_o,
  output logic [31:0]     perf_mispred_cnt_o
);
  brn_state_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic cmp_taken, cmp_illegal, resolve, taken, mispred;
  logic [PC_W-1:0] actual_pc;
  brn_cmp u_cmp (
    .funct3 (funct3_ex_i),
    .a      (r_data_p1_ex_i),
    .b      (r_data_p2_ex_i),
    .taken  (cmp_taken),
    .illegal(cmp_illegal)
  );
  // Prediction is judged on the full next PC, so a right direction with a wrong target still redirects.
  always_comb begin
    resolve = valid_ex_i & (is_b_type_ex_i | jump_ex_i) & (state_q == IDLE);
    taken = jump_ex_i | cmp_taken;
    actual_pc = jump_ex_i ? (jump_tgt_ex_i & ~32'd1) : cmp_taken ? next_brn_pc_ex_i : next_seq_pc_ex_i;
    mispred = resolve & (actual_pc != next_pred_pc_ex_i);
    state_d = state_q == IDLE ? (mispred ? SHADOW : IDLE) : (cnt_q == 3'd1 ? IDLE : SHADOW);
    cnt_d = state_q == IDLE ? (mispred ? 3'(SHADOW_CYCLES) : cnt_q) : cnt_q - 3'd1;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      redirect_o <= 1'b0;
      redirect_pc_o <= '0;
      flush_ex_o <= 1'b0;
      bp_upd_valid_o <= 1'b0;
      bp_upd_pc_o <= '0;
      bp_upd_taken_o <= 1'b0;
      bp_upd_tgt_o <= '0;
      illegal_brn_o <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      redirect_o <= mispred;
      flush_ex_o <= mispred;
      bp_upd_valid_o <= resolve;
      illegal_brn_o <= resolve & ~jump_ex_i & cmp_illegal;
      if (mispred) redirect_pc_o <= actual_pc;
      if (resolve) begin
        bp_upd_pc_o <= curr_pc_ex_i;
        bp_upd_taken_o <= taken;
        bp_upd_tgt_o <= actual_pc;
      end
    end
  end
`ifdef BRN_PERF_CNT_EN
  logic [31:0] perf_brn_cnt_q, perf_mispred_cnt_q;
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_brn_cnt_q <= '0;
      perf_mispred_cnt_q <= '0;
    end else begin
      perf_brn_cnt_q <= perf_brn_cnt_q + 32'(resolve);
      perf_mispred_cnt_q <= perf_mispred_cnt_q + 32'(mispred);
    end
  end
  assign perf_brn_cnt_o = perf_brn_cnt_q;
  assign perf_mispred_cnt_o = perf_mispred_cnt_q;
`else
  logic unused_pred;
  assign unused_pred = brn_pred_ex_i;
  assign perf_brn_cnt_o = '0;
  assign perf_mispred_cnt_o = '0;
`endif
`ifdef BRN_PERF_CNT_EN
  logic unused_pred_p;
  assign unused_pred_p = brn_pred_ex_i;
`endif
endmodule

// File: tb/tb_ex_brn_resolve.sv
// tb_ex_brn_resolve: random and directed stimulus against a cycle-level behavioural model
module tb_ex_brn_resolve;
  localparam int SC = 3;
  logic clk = 0, reset = 1;
  logic valid, is_b, jump, pred;
  logic [2:0] f3;
  logic [31:0] p1, p2, pc, seq, brn, npred, tgt;
  logic redirect, flush, bpv, bpt, ill;
  logic [31:0] rpc, bppc, bptgt, pbc, pmc;
  int total = 0, passed = 0;
  int shadow = 0;
  logic e_redirect, e_flush, e_bpv, e_bpt, e_ill;
  logic [31:0] e_rpc, e_bppc, e_bptgt, e_brn_cnt, e_mis_cnt;

  ex_brn_resolve #(.SHADOW_CYCLES(SC)) u_dut (
    .clk(clk), .reset(reset), .valid_ex_i(valid), .is_b_type_ex_i(is_b), .jump_ex_i(jump),
    .brn_pred_ex_i(pred), .funct3_ex_i(f3), .r_data_p1_ex_i(p1), .r_data_p2_ex_i(p2),
    .curr_pc_ex_i(pc), .next_seq_pc_ex_i(seq), .next_brn_pc_ex_i(brn), .next_pred_pc_ex_i(npred),
    .jump_tgt_ex_i(tgt), .redirect_o(redirect), .redirect_pc_o(rpc), .flush_ex_o(flush),
    .bp_upd_valid_o(bpv), .bp_upd_pc_o(bppc), .bp_upd_taken_o(bpt), .bp_upd_tgt_o(bptgt),
    .illegal_brn_o(ill), .perf_brn_cnt_o(pbc), .perf_mispred_cnt_o(pmc)
  );

  always #5 clk = ~clk;

  function automatic bit cond(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    int signed sa = a, sb = b;
    case (f)
      3'b000: return a == b;
      3'b001: return a != b;
      3'b100: return sa < sb;
      3'b101: return sa >= sb;
      3'b110: return a < b;
      3'b111: return a >= b;
      default: return 0;
    endcase
  endfunction

  task automatic model();
    bit res, tk;
    logic [31:0] act;
    e_redirect = 0; e_flush = 0; e_bpv = 0; e_ill = 0;
    if (reset) begin
      shadow = 0;
      e_rpc = 0; e_bppc = 0; e_bpt = 0; e_bptgt = 0; e_brn_cnt = 0; e_mis_cnt = 0;
      return;
    end
    res = valid && (is_b || jump) && shadow == 0;
    if (shadow > 0) shadow--;
    if (!res) return;
    tk = jump ? 1'b1 : cond(f3, p1, p2);
    act = jump ? {tgt[31:1], 1'b0} : (tk ? brn : seq);
    e_bpv = 1; e_bppc = pc; e_bpt = tk; e_bptgt = act;
    e_ill = !jump && (f3 == 3'b010 || f3 == 3'b011);
    e_brn_cnt++;
    if (act != npred) begin
      e_redirect = 1; e_flush = 1; e_rpc = act; e_mis_cnt++;
      shadow = SC;
    end
  endtask

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    else passed++;
  endtask

  task automatic cyc();
    model();
    @(posedge clk);
    #1;
    chk("redirect", 32'(redirect), 32'(e_redirect));
    chk("flush", 32'(flush), 32'(e_flush));
    chk("redirect_pc", rpc, e_rpc);
    chk("bp_valid", 32'(bpv), 32'(e_bpv));
    chk("bp_pc", bppc, e_bppc);
    chk("bp_taken", 32'(bpt), 32'(e_bpt));
    chk("bp_tgt", bptgt, e_bptgt);
    chk("illegal", 32'(ill), 32'(e_ill));
`ifdef BRN_PERF_CNT_EN
    chk("perf_brn", pbc, e_brn_cnt);
    chk("perf_mis", pmc, e_mis_cnt);
`else
    chk("perf_brn", pbc, 32'd0);
    chk("perf_mis", pmc, 32'd0);
`endif
  endtask

  task automatic idle();
    valid = 0; is_b = 0; jump = 0; pred = 0; f3 = 0; p1 = 0; p2 = 0;
    pc = 32'h100; seq = 32'h104; brn = 32'h200; npred = 32'h104; tgt = 0;
  endtask

  task automatic br(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                    input logic [31:0] np);
    idle();
    valid = 1; is_b = 1; f3 = f; p1 = a; p2 = b; npred = np;
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 0;
      1: return 1;
      2: return 5;
      3: return 32'hFFFFFFFF;
      4: return 32'h80000000;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    idle();
    reset = 1;
    cyc(); cyc();
    chk("reset_redirect_pc", rpc, 32'h0);
    chk("reset_bp_valid", 32'(bpv), 32'h0);
    reset = 0;
    // BEQ taken against a not-taken prediction
    br(3'b000, 5, 5, 32'h104); cyc();
    chk("beq_redirect", 32'(redirect), 32'h1);
    chk("beq_pc", rpc, 32'h200);
    chk("beq_taken", 32'(bpt), 32'h1);
    idle(); repeat (SC) cyc();
    // BLT signed taken then BLTU not taken, both correctly predicted
    br(3'b100, 32'hFFFFFFFF, 1, 32'h200); cyc();
    chk("blt_taken", 32'(bpt), 32'h1);
    chk("blt_noredir", 32'(redirect), 32'h0);
    br(3'b110, 32'hFFFFFFFF, 1, 32'h104); cyc();
    chk("bltu_taken", 32'(bpt), 32'h0);
    chk("bltu_valid", 32'(bpv), 32'h1);
    // JALR with odd target, then a mispredicting branch in the shadow
    idle(); valid = 1; jump = 1; tgt = 32'h1235; npred = 32'h1000; cyc();
    chk("jalr_pc", rpc, 32'h1234);
    br(3'b000, 5, 5, 32'h104); cyc();
    chk("shadow_noredir", 32'(redirect), 32'h0);
    chk("shadow_nobp", 32'(bpv), 32'h0);
    repeat (SC - 1) cyc();
    cyc();
    chk("after_shadow", 32'(redirect), 32'h1);
    // illegal funct3 then reset mid-shadow
    idle(); repeat (SC) cyc();
    br(3'b010, 0, 0, 32'h200); cyc();
    chk("illegal_pulse", 32'(ill), 32'h1);
    chk("illegal_redir_seq", rpc, 32'h104);
    br(3'b000, 1, 1, 32'h104); reset = 1; cyc();
    chk("reset_mid_pc", rpc, 32'h0);
    reset = 0; cyc();
    chk("post_reset_resolve", 32'(bpv), 32'h1);
`ifdef BRN_PERF_CNT_EN
    idle(); repeat (SC) cyc();
    force u_dut.perf_brn_cnt_q = 32'hFFFFFFFF;
    #1 release u_dut.perf_brn_cnt_q;
    e_brn_cnt = 32'hFFFFFFFF;
    br(3'b001, 1, 1, 32'h104); cyc();
    chk("perf_wrap", pbc, 32'h0);
`else
    idle(); repeat (SC) cyc();
    repeat (10) begin br(3'b000, 1, 1, 32'h200); cyc(); end
    chk("perf_off", pbc | pmc, 32'h0);
`endif
    repeat (3000) begin
      valid = $urandom_range(0, 3) != 0;
      is_b = $urandom_range(0, 1);
      jump = $urandom_range(0, 3) == 0;
      pred = $urandom_range(0, 1);
      f3 = 3'($urandom);
      p1 = pick(); p2 = $urandom_range(0, 1) ? p1 : pick();
      pc = $urandom & ~32'd3; seq = pc + 4; brn = $urandom & ~32'd3;
      tgt = $urandom;
      case ($urandom_range(0, 3))
        0: npred = seq;
        1: npred = brn;
        2: npred = {tgt[31:1], 1'b0};
        default: npred = $urandom;
      endcase
      reset = $urandom_range(0, 63) == 0;
      cyc();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
